// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues one req/ack read to instruction memory at a time
// and queues {pc, instr} pairs toward decode; a redirect flushes everything in flight.
module ifetch_unit #(
   parameter int unsigned IMEM_AW = 10,
   parameter int unsigned DEPTH   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        pc_in,
   input  logic               redirect,
   output logic               pc_hold,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [31:0]        id_instr,
   output logic [31:0]        id_pc
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 req_d;
   logic [IMEM_AW-1:0]   addr_d;
   logic [31:0]          req_pc_q, req_pc_d;
   logic                 launch;
   logic                 push;
   logic                 pop;

   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        count_q;
   logic [31:0]          mem_pc_q    [DEPTH];
   logic [31:0]          mem_instr_q [DEPTH];

   // One fetch outstanding at most; held off while reset, redirecting or FIFO full
   assign launch  = !reset && (state_q == IDLE) && !redirect && (count_q < CW'(DEPTH));
   assign pc_hold = !launch;

   assign id_valid = (count_q != '0);
   assign id_instr = mem_instr_q[rd_ptr_q];
   assign id_pc    = mem_pc_q[rd_ptr_q];
   assign pop      = id_valid && id_ready && !redirect;

   // Request state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         imem_req  <= 1'b0;
         imem_addr <= '0;
         req_pc_q  <= '0;
      end else begin
         state_q   <= state_d;
         imem_req  <= req_d;
         imem_addr <= addr_d;
         req_pc_q  <= req_pc_d;
      end
   end

   // Next-state: a request in flight during a redirect must still be acked, then dropped
   always_comb begin
      state_d  = state_q;
      req_d    = imem_req;
      addr_d   = imem_addr;
      req_pc_d = req_pc_q;
      push     = 1'b0;
      case (state_q)
         IDLE: begin
            if (launch) begin
               req_d    = 1'b1;
               addr_d   = pc_in[IMEM_AW-1:0];
               req_pc_d = pc_in;
               state_d  = REQ;
            end
         end
         REQ: begin
            if (imem_ack) begin
               push    = !redirect;
               req_d   = 1'b0;
               state_d = IDLE;
            end else if (redirect) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (imem_ack) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Decode FIFO; a redirect clears it and wins over any push or pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc_q[i]    <= '0;
            mem_instr_q[i] <= '0;
         end
      end else if (redirect) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_pc_q[wr_ptr_q]    <= req_pc_q;
            mem_instr_q[wr_ptr_q] <= imem_rdata;
            wr_ptr_q              <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a randomized run, all checked
// against a transaction-level model of the fetch queue kept in the bench.
module tb_ifetch_unit;

   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   pc;
   logic          redirect;
   logic          pc_hold;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [31:0]   imem_rdata;
   logic          id_valid;
   logic          id_ready;
   logic [31:0]   id_instr;
   logic [31:0]   id_pc;

   logic [31:0]   mem [1024];
   assign imem_rdata = mem[imem_addr];

   always #5 clk = ~clk;

   ifetch_unit #(.IMEM_AW(AW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_in      (pc),
      .redirect   (redirect),
      .pc_hold    (pc_hold),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .id_valid   (id_valid),
      .id_ready   (id_ready),
      .id_instr   (id_instr),
      .id_pc      (id_pc)
   );

   int passed = 0;
   int total  = 0;

   // Reference model: one outstanding fetch (possibly stale) and a queue of delivered pairs
   bit            m_out;
   bit            m_stale;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_pc;
   logic [31:0]   q_pc    [$];
   logic [31:0]   q_instr [$];
   logic [31:0]   tgt;

   function automatic bit exp_hold();
      return reset || m_out || redirect || (q_pc.size() >= DEPTH);
   endfunction

   task automatic model_clear();
      m_out = 0; m_stale = 0; m_addr = '0; m_pc = '0;
      q_pc.delete(); q_instr.delete();
   endtask

   task automatic drive(input logic rd, input logic ak, input logic rdy);
      redirect = rd; imem_ack = ak; id_ready = rdy;
      #1;
   endtask

   // Applies the fetch rules for this cycle's inputs, then clocks the DUT and the PC register
   task automatic advance();
      bit          launch, push;
      logic [31:0] next_pc;
      logic [31:0] push_instr;
      launch     = !m_out && !redirect && (q_pc.size() < DEPTH);
      push       = m_out && imem_ack && !m_stale && !redirect;
      push_instr = mem[m_addr];
      if (redirect) begin
         q_pc.delete(); q_instr.delete();
      end else begin
         if (id_ready && q_pc.size() > 0) begin
            void'(q_pc.pop_front()); void'(q_instr.pop_front());
         end
         if (push) begin
            q_pc.push_back(m_pc); q_instr.push_back(push_instr);
         end
      end
      if (m_out && imem_ack) m_out = 0;
      else if (m_out && redirect) m_stale = 1;
      if (launch) begin
         m_out = 1; m_stale = 0; m_addr = pc[AW-1:0]; m_pc = pc;
      end
      next_pc = redirect ? tgt : (pc_hold ? pc : pc + 32'd1);
      @(posedge clk);
      #1;
      pc = next_pc;
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [31:0] start_pc);
      reset = 1; redirect = 0; imem_ack = 0; id_ready = 0; pc = start_pc;
      model_clear();
      @(negedge clk); @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; redirect = 0; imem_ack = 0; id_ready = 0; pc = 32'h0000_0123;
      model_clear();
      #1;
      total++; if (imem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", imem_req); else passed++;
      total++; if (imem_addr !== '0) $display("FAIL rst_addr got=%h exp=0", imem_addr); else passed++;
      total++; if (id_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", id_valid); else passed++;
      total++; if (id_instr !== 32'd0) $display("FAIL rst_instr got=%h exp=0", id_instr); else passed++;
      total++; if (id_pc !== 32'd0) $display("FAIL rst_pc got=%h exp=0", id_pc); else passed++;
      total++; if (pc_hold !== 1'b1) $display("FAIL rst_hold got=%b exp=1", pc_hold); else passed++;
      @(negedge clk); @(negedge clk);
      reset = 0;
      drive(0, 0, 0);
      total++; if (pc_hold !== 1'b0) $display("FAIL rst_first_launch hold got=%b exp=0", pc_hold); else passed++;
      advance();
   endtask

   // Zero-wait memory: one instruction every second cycle, PC 0,1,2,3 in order
   task automatic test_stream();
      int k = 0;
      do_reset(32'd0);
      for (int c = 0; c < 9; c++) begin
         drive(0, imem_req, 1);
         total++; if (pc_hold !== (c % 2 == 1)) $display("FAIL stream_hold c=%0d got=%b exp=%b", c, pc_hold, (c % 2 == 1)); else passed++;
         total++; if (id_valid !== (c >= 2 && c % 2 == 0)) $display("FAIL stream_valid c=%0d got=%b", c, id_valid); else passed++;
         if (c >= 2 && c % 2 == 0) begin
            total++; if (id_pc !== 32'(k)) $display("FAIL stream_pc got=%h exp=%h", id_pc, 32'(k)); else passed++;
            total++; if (id_instr !== mem[k]) $display("FAIL stream_instr got=%h exp=%h", id_instr, mem[k]); else passed++;
            k++;
         end
         advance();
      end
   endtask

   // Decode stalled: exactly DEPTH entries queue up, then drain in order and fetch resumes
   task automatic test_backpressure();
      do_reset(32'd0);
      for (int c = 0; c < 10; c++) begin
         drive(0, imem_req, 0);
         total++; if (pc_hold !== exp_hold()) $display("FAIL bp_hold c=%0d got=%b exp=%b", c, pc_hold, exp_hold()); else passed++;
         if (c >= 4) begin
            total++; if (imem_req !== 1'b0) $display("FAIL bp_third_req c=%0d got=%b exp=0", c, imem_req); else passed++;
         end
         advance();
      end
      drive(0, 0, 1);
      total++; if (id_valid !== 1'b1) $display("FAIL bp_valid got=%b exp=1", id_valid); else passed++;
      total++; if (pc_hold !== 1'b1) $display("FAIL bp_full_hold got=%b exp=1", pc_hold); else passed++;
      total++; if (id_pc !== 32'd0) $display("FAIL bp_pop0 got=%h exp=0", id_pc); else passed++;
      advance();
      drive(0, 0, 1);
      total++; if (id_pc !== 32'd1) $display("FAIL bp_pop1 got=%h exp=1", id_pc); else passed++;
      total++; if (pc_hold !== 1'b0) $display("FAIL bp_resume_hold got=%b exp=0", pc_hold); else passed++;
      advance();
      drive(0, 0, 1);
      total++; if (imem_req !== 1'b1 || imem_addr !== 10'd2) $display("FAIL bp_resume_req got=%b/%h exp=1/002", imem_req, imem_addr); else passed++;
      advance();
   endtask

   // Memory answers three cycles late: request held stable, instruction delivered once
   task automatic test_delayed_ack();
      logic [31:0] p;
      p = $urandom;
      do_reset(p);
      drive(0, 0, 1); advance();
      for (int c = 0; c < 3; c++) begin
         drive(0, 0, 1);
         total++; if (imem_req !== 1'b1) $display("FAIL dly_req c=%0d got=%b exp=1", c, imem_req); else passed++;
         total++; if (imem_addr !== p[AW-1:0]) $display("FAIL dly_addr c=%0d got=%h exp=%h", c, imem_addr, p[AW-1:0]); else passed++;
         total++; if (pc_hold !== 1'b1) $display("FAIL dly_hold c=%0d got=%b exp=1", c, pc_hold); else passed++;
         advance();
      end
      drive(0, 1, 1); advance();
      drive(0, 0, 1);
      total++; if (id_valid !== 1'b1) $display("FAIL dly_valid got=%b exp=1", id_valid); else passed++;
      total++; if (id_pc !== p) $display("FAIL dly_pc got=%h exp=%h", id_pc, p); else passed++;
      total++; if (id_instr !== mem[p[AW-1:0]]) $display("FAIL dly_instr got=%h exp=%h", id_instr, mem[p[AW-1:0]]); else passed++;
      advance();
      drive(0, 0, 1);
      total++; if (id_valid !== 1'b0) $display("FAIL dly_once got=%b exp=0", id_valid); else passed++;
      total++; if (imem_addr !== AW'(p + 32'd1)) $display("FAIL dly_next_addr got=%h exp=%h", imem_addr, AW'(p + 32'd1)); else passed++;
      advance();
   endtask

   // Redirect while waiting on memory: late data dropped, next fetch goes to the target
   task automatic test_redirect_req();
      do_reset(32'd7);
      drive(0, 0, 1); advance();
      tgt = 32'h0000_0040;
      drive(1, 0, 1);
      total++; if (pc_hold !== 1'b1) $display("FAIL rdq_hold got=%b exp=1", pc_hold); else passed++;
      advance();
      for (int c = 0; c < 2; c++) begin
         drive(0, 0, 1);
         total++; if (imem_req !== 1'b1) $display("FAIL rdq_drain_req c=%0d got=%b exp=1", c, imem_req); else passed++;
         total++; if (pc_hold !== 1'b1) $display("FAIL rdq_drain_hold c=%0d got=%b exp=1", c, pc_hold); else passed++;
         advance();
      end
      drive(0, 1, 1); advance();
      drive(0, 0, 1);
      total++; if (id_valid !== 1'b0) $display("FAIL rdq_discard got=%b exp=0", id_valid); else passed++;
      total++; if (pc_hold !== 1'b0) $display("FAIL rdq_relaunch got=%b exp=0", pc_hold); else passed++;
      advance();
      drive(0, 0, 1);
      total++; if (imem_req !== 1'b1 || imem_addr !== 10'h040) $display("FAIL rdq_target got=%b/%h exp=1/040", imem_req, imem_addr); else passed++;
      advance();
   endtask

   // Redirect coinciding with an ack while one entry is queued: everything flushed
   task automatic test_redirect_ack();
      logic [31:0] p;
      p = 32'h0000_0100 + 32'($urandom_range(0, 255));
      do_reset(p);
      drive(0, 0, 0); advance();
      drive(0, 1, 0); advance();
      drive(0, 0, 0);
      total++; if (id_valid !== 1'b1 || id_pc !== p) $display("FAIL rda_queued got=%b/%h exp=1/%h", id_valid, id_pc, p); else passed++;
      advance();
      drive(0, 0, 0); advance();
      tgt = $urandom;
      drive(1, 1, 0); advance();
      drive(0, 0, 0);
      total++; if (id_valid !== 1'b0) $display("FAIL rda_flush got=%b exp=0", id_valid); else passed++;
      advance();
      drive(0, 0, 0);
      total++; if (id_valid !== 1'b0) $display("FAIL rda_nopush got=%b exp=0", id_valid); else passed++;
      total++; if (imem_addr !== tgt[AW-1:0]) $display("FAIL rda_target got=%h exp=%h", imem_addr, tgt[AW-1:0]); else passed++;
      advance();
   endtask

   // Reset while a read is outstanding; a stray ack after release must be ignored
   task automatic test_reset_mid_req();
      do_reset(32'd3);
      drive(0, 0, 1); advance();
      drive(0, 0, 1);
      total++; if (imem_req !== 1'b1) $display("FAIL rmr_pre_req got=%b exp=1", imem_req); else passed++;
      reset = 1; pc = 32'd0;
      #1;
      total++; if (imem_req !== 1'b0) $display("FAIL rmr_async_req got=%b exp=0", imem_req); else passed++;
      model_clear();
      @(negedge clk);
      reset = 0;
      drive(0, 1, 1);
      total++; if (imem_req !== 1'b0) $display("FAIL rmr_stray_req got=%b exp=0", imem_req); else passed++;
      advance();
      drive(0, 0, 1);
      total++; if (id_valid !== 1'b0) $display("FAIL rmr_valid got=%b exp=0", id_valid); else passed++;
      total++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) $display("FAIL rmr_relaunch got=%b/%h exp=1/000", imem_req, imem_addr); else passed++;
      advance();
   endtask

   // Random redirects, memory latency and decode stalls against the queue model
   task automatic test_random();
      bit rd, ak, rdy;
      do_reset($urandom);
      for (int c = 0; c < 600; c++) begin
         rd  = ($urandom_range(0, 9) == 0);
         ak  = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
         rdy = ($urandom_range(0, 4) != 0);
         tgt = $urandom;
         drive(rd, ak, rdy);
         total++; if (imem_req !== m_out) $display("FAIL rnd_req c=%0d got=%b exp=%b", c, imem_req, m_out); else passed++;
         total++; if (imem_addr !== m_addr) $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr, m_addr); else passed++;
         total++; if (pc_hold !== exp_hold()) $display("FAIL rnd_hold c=%0d got=%b exp=%b", c, pc_hold, exp_hold()); else passed++;
         total++; if (id_valid !== (q_pc.size() != 0)) $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, id_valid, (q_pc.size() != 0)); else passed++;
         if (q_pc.size() != 0) begin
            total++; if (id_pc !== q_pc[0] || id_instr !== q_instr[0]) $display("FAIL rnd_head c=%0d got=%h/%h exp=%h/%h", c, id_pc, id_instr, q_pc[0], q_instr[0]); else passed++;
         end
         advance();
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      tgt = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_delayed_ack();
      test_redirect_req();
      test_redirect_ack();
      test_reset_mid_req();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
